// File: rtl/mem8x8_ctrl_pkg.sv
// Shared widths, op codes, FSM encoding and request payload for the 8x8 bytecell access sequencer.
package mem8x8_ctrl_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NCELLS = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem8x8_ctrl_if.sv
// Request/response bus between a requester (master) and mem8x8_ctrl (slave).
// MEM8X8_CTRL_RSP_STALL_EN adds rsp_ready for back-pressured responses.
interface mem8x8_ctrl_if;
  import mem8x8_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef MEM8X8_CTRL_RSP_STALL_EN
  logic              rsp_ready;

  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
`endif

endinterface

// File: rtl/mem8x8_addr_dec.sv
// Combinational address-to-one-hot cell select decoder with enable.
module mem8x8_addr_dec
  import mem8x8_ctrl_pkg::*;
(
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NCELLS-1:0] sel_c_o
);

  always_comb begin
    sel_c_o = '0;
    if (en_i) sel_c_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/mem8x8_ctrl.sv
// Access sequencer for the 8x8 bytecell array: one request at a time, registered cell strobes.
// Optional MEM8X8_CTRL_RSP_STALL_EN holds the response until rsp_ready.
module mem8x8_ctrl
  import mem8x8_ctrl_pkg::*;
#(
  parameter int unsigned WR_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem8x8_ctrl_if.slave      bus,
  output logic [NCELLS-1:0] cell_sel_o,
  output logic              cell_op_o,
  output logic [DATA_W-1:0] cell_inp_o,
  input  logic [DATA_W-1:0] cell_outp_i
);

  localparam int unsigned      HOLD_EFF  = (WR_HOLD == 0) ? 32'd1 : WR_HOLD;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 32'd1);

  if (WR_HOLD > 15) begin : g_hold_range
    $error("mem8x8_ctrl: WR_HOLD must be 0..15");
  end

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NCELLS-1:0]   cell_sel_q;
  logic                cell_op_q, cell_op_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                accept_c;
  logic                dec_en_c;
  logic [ADDR_W-1:0]   dec_addr_c;
  logic [NCELLS-1:0]   dec_sel_c;

  assign accept_c = bus.req_valid & req_ready_q;

  // Decode the incoming address on accept so cell_sel is already valid in SETUP.
  assign dec_addr_c = (state_q == ST_IDLE) ? bus.req_addr : req_q.addr;
  assign dec_en_c   = (state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_READ);

  mem8x8_addr_dec u_addr_dec (
    .en_i    (dec_en_c),
    .addr_i  (dec_addr_c),
    .sel_c_o (dec_sel_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      cell_sel_q  <= '0;
      cell_op_q   <= OP_READ;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      cell_sel_q  <= dec_sel_c;
      cell_op_q   <= cell_op_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    cell_op_d   = OP_READ;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SETUP;
          req_d   = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        end
      end
      ST_SETUP: begin
        state_d = req_q.we ? ST_WRITE : ST_READ;
        cnt_d   = HOLD_LOAD;
      end
      ST_WRITE: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_READ: begin
        rdata_d = cell_outp_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
`ifdef MEM8X8_CTRL_RSP_STALL_EN
        state_d = bus.rsp_ready ? ST_IDLE : ST_RESP;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    cell_op_d   = (state_d == ST_WRITE) ? OP_WRITE : OP_READ;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign cell_sel_o    = cell_sel_q;
  assign cell_op_o     = cell_op_q;
  assign cell_inp_o    = req_q.wdata;

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Scoreboard bench for mem8x8_ctrl with a behavioural 8x8 bytecell array model.
module tb_mem8x8_ctrl;
  import mem8x8_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem8x8_ctrl_if bus();

  logic [NCELLS-1:0] cell_sel;
  logic              cell_op;
  logic [DATA_W-1:0] cell_inp;
  logic [DATA_W-1:0] cell_outp;
  logic              rsp_ready_tb = 1'b1;
  logic              mem_clr = 1'b1;
  logic [7:0]        mem [NCELLS];

`ifdef MEM8X8_CTRL_RSP_STALL_EN
  assign bus.rsp_ready = rsp_ready_tb;
`endif

  mem8x8_ctrl #(.WR_HOLD(1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cell_sel_o  (cell_sel),
    .cell_op_o   (cell_op),
    .cell_inp_o  (cell_inp),
    .cell_outp_i (cell_outp)
  );

  // Array model: selected cell latches inp on op=1, unselected cells drive 0.
  always_comb begin
    cell_outp = '0;
    for (int i = 0; i < NCELLS; i++)
      if (cell_sel[i] && !cell_op) cell_outp = cell_outp | mem[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCELLS; i++) begin
      if (mem_clr) mem[i] <= 8'h00;
      else if (cell_sel[i] && cell_op) mem[i] <= cell_inp;
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one-hot select and scoreboard pop on each consumed response.
  always @(negedge clk) begin
    if (cell_sel != '0) chk("sel_onehot", 32'($countones(cell_sel)), 32'd1);
    if (bus.rsp_valid && rsp_ready_tb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h expected no response at %0t", bus.rsp_rdata, $time);
      end else begin
        exp_v = exp_q.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_v));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  // Issue one request; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                       input logic push, input logic [7:0] exp);
    @(negedge clk);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int acc;
    int first_k;
    int gap;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata",    32'(bus.rsp_rdata), 32'd0);
    chk("rst_sel",      32'(cell_sel), 32'd0);
    chk("rst_op",       32'(cell_op), 32'd0);
    chk("rst_inp",      32'(cell_inp), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(bus.req_ready), 32'd0);
    mem_clr = 1'b0;
    @(negedge clk);
    chk("ready_after_edge", 32'(bus.req_ready), 32'd1);

    // Cycle-accurate write of 0xAA to cell 5
    issue(1'b1, 3'd5, 8'hAA, 1'b1, 8'h00);
    @(negedge clk);
    chk("wr_c1_sel",   32'(cell_sel), 32'h20);
    chk("wr_c1_op",    32'(cell_op), 32'd0);
    chk("wr_c1_inp",   32'(cell_inp), 32'hAA);
    chk("wr_c1_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("wr_c2_sel",   32'(cell_sel), 32'h20);
    chk("wr_c2_op",    32'(cell_op), 32'd1);
    chk("wr_c2_inp",   32'(cell_inp), 32'hAA);
    @(negedge clk);
    chk("wr_c3_sel",   32'(cell_sel), 32'd0);
    chk("wr_c3_op",    32'(cell_op), 32'd0);
    chk("wr_c3_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_c3_inp",   32'(cell_inp), 32'hAA);
    @(negedge clk);
    chk("wr_c4_ready", 32'(bus.req_ready), 32'd1);
    chk("wr_c4_valid", 32'(bus.rsp_valid), 32'd0);

    // Reads and a second write; write responses keep the last read data
    issue(1'b0, 3'd5, 8'h00, 1'b1, 8'hAA);
    issue(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
    issue(1'b1, 3'd3, 8'h5C, 1'b1, 8'h00);
    issue(1'b0, 3'd3, 8'h00, 1'b1, 8'h5C);

    // Request held for 8 cycles: accepted only when ready
    @(negedge clk);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd2;
    bus.req_wdata = 8'h33;
    acc = 0;
    first_k = -1;
    gap = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.req_ready) begin
        acc++;
        if (first_k < 0) first_k = k;
        else gap = k - first_k;
        exp_q.push_back(8'h5C);
      end
      @(posedge clk);
      if (k == 7) #1 bus.req_valid = 1'b0;
      @(negedge clk);
    end
    chk("hold_accepts", 32'(acc), 32'd2);
    chk("hold_gap",     32'(gap), 32'd4);

    // Reset asserted in the WRITE state
    issue(1'b1, 3'd6, 8'h77, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_op",  32'(cell_op), 32'd1);
    chk("midrst_pre_sel", 32'(cell_sel), 32'h40);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_op",    32'(cell_op), 32'd0);
    chk("midrst_sel",   32'(cell_sel), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rdata", 32'(bus.rsp_rdata), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'd5, 8'h00, 1'b1, 8'hAA);

`ifdef MEM8X8_CTRL_RSP_STALL_EN
    // Stalled read response
    issue(1'b1, 3'd4, 8'hCC, 1'b1, 8'hAA);
    @(negedge clk);
    wait_ready();
    rsp_ready_tb = 1'b0;
    issue(1'b0, 3'd4, 8'h00, 1'b1, 8'hCC);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rdata", 32'(bus.rsp_rdata), 32'hCC);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      if (k == 1) #1 rsp_ready_tb = 1'b1;
      @(negedge clk);
    end
    chk("stall_exit_ready", 32'(bus.req_ready), 32'd1);
    chk("stall_exit_valid", 32'(bus.rsp_valid), 32'd0);
`endif

    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
